led_sequencer: RTL

LED_SEQUENCER -- requirements
Module: led_sequencer

---
 rtl/led_sequencer.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/led_sequencer.sv
// LED pattern sequencer: a CPU-programmable Avalon-MM slave that periodically
// writes an evolving 8-bit pattern to an LED PIO through an Avalon-MM master port.
module led_sequencer (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [1:0]  pio_address,
    output logic        pio_chipselect,
    output logic        pio_write_n,
    output logic [31:0] pio_writedata
);
    typedef enum logic [1:0] {IDLE, LOAD, WRITE, WAIT} state_t;

    state_t      r_state, w_state_next;
    logic        r_enable;
    logic [1:0]  r_mode;
    logic [23:0] r_period;
    logic [7:0]  r_pattern;
    logic [7:0]  r_cur, w_cur_next, w_mode_cur;
    logic        r_dir, w_dir_next, w_mode_dir;
    logic        r_reload, w_reload_next;
    logic [23:0] r_cnt, w_cnt_next;
    logic [23:0] w_p_eff;
    logic        w_wr, w_pat_wr, w_running, w_update;
    logic        r_pio_cs;
    logic [7:0]  r_pio_data;
    logic        w_unused;

    assign w_wr      = chipselect & ~write_n;
    assign w_pat_wr  = w_wr && (address == 2'd2);
    assign w_running = (r_state != IDLE);
    assign w_p_eff   = (r_period < 24'd2) ? 24'd2 : r_period;
    assign w_unused  = &{1'b0, writedata[31:24]};

    // Pattern update for the current mode; dir = 1 means moving right
    always_comb begin
        w_mode_cur = r_cur;
        w_mode_dir = r_dir;
        case (r_mode)
            2'd1: w_mode_cur = {r_cur[6:0], r_cur[7]};
            2'd2: begin
                if (!r_dir) begin
                    if (r_cur[7]) begin
                        w_mode_dir = 1'b1;
                        w_mode_cur = r_cur >> 1;
                    end else begin
                        w_mode_cur = r_cur << 1;
                    end
                end else begin
                    if (r_cur[0]) begin
                        w_mode_dir = 1'b0;
                        w_mode_cur = r_cur << 1;
                    end else begin
                        w_mode_cur = r_cur >> 1;
                    end
                end
            end
            2'd3: w_mode_cur = ~r_cur;
            default: ;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        w_cur_next   = r_cur;
        w_dir_next   = r_dir;
        w_cnt_next   = r_cnt;
        w_update     = 1'b0;
        if (!r_enable) begin
            w_state_next = IDLE;
        end else begin
            case (r_state)
                IDLE: w_state_next = LOAD;
                LOAD: begin
                    w_state_next = WRITE;
                    w_cur_next   = r_pattern;
                    w_dir_next   = 1'b0;
                end
                WRITE: begin
                    w_state_next = WAIT;
                    w_cnt_next   = 24'd0;
                end
                WAIT: begin
                    // WAIT lasts P-1 cycles so that writes are P cycles apart
                    if (r_cnt >= w_p_eff - 24'd2) begin
                        w_state_next = WRITE;
                        w_update     = 1'b1;
                        if (r_reload) begin
                            w_cur_next = r_pattern;
                            w_dir_next = 1'b0;
                        end else begin
                            w_cur_next = w_mode_cur;
                            w_dir_next = w_mode_dir;
                        end
                    end else if (r_cnt != 24'hFF_FFFF) begin
                        w_cnt_next = r_cnt + 24'd1;
                    end
                end
                default: w_state_next = IDLE;
            endcase
        end
    end

    // A PATTERN write coinciding with an update survives for the next one
    assign w_reload_next = ((w_update || (r_state == LOAD)) ? 1'b0 : r_reload)
                           | (w_pat_wr & w_running);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_enable   <= 1'b0;
            r_mode     <= 2'd0;
            r_period   <= 24'd16;
            r_pattern  <= 8'h01;
            r_cur      <= 8'h00;
            r_dir      <= 1'b0;
            r_reload   <= 1'b0;
            r_cnt      <= 24'd0;
            r_pio_cs   <= 1'b0;
            r_pio_data <= 8'h00;
        end else begin
            r_state  <= w_state_next;
            r_cur    <= w_cur_next;
            r_dir    <= w_dir_next;
            r_cnt    <= w_cnt_next;
            r_reload <= w_reload_next;
            if (w_wr) begin
                case (address)
                    2'd0: begin
                        r_enable <= writedata[0];
                        r_mode   <= writedata[2:1];
                    end
                    2'd1: r_period  <= writedata[23:0];
                    2'd2: r_pattern <= writedata[7:0];
                    default: ;
                endcase
            end
            r_pio_cs <= (w_state_next == WRITE);
            if (w_state_next == WRITE) begin
                r_pio_data <= w_cur_next;
            end
        end
    end

    assign pio_address    = 2'd0;
    assign pio_chipselect = r_pio_cs;
    assign pio_write_n    = ~r_pio_cs;
    assign pio_writedata  = {24'd0, r_pio_data};

    always_comb begin
        readdata = 32'd0;
        case (address)
            2'd0:    readdata = {29'd0, r_mode, r_enable};
            2'd1:    readdata = {8'd0, r_period};
            2'd2:    readdata = {24'd0, r_pattern};
            default: readdata = {16'd0, r_cur, 6'd0, r_dir, w_running};
        endcase
    end
endmodule
